// File: rtl/seg_arbiter_if.sv
// Requester/display bundle for seg_arbiter: scan strobe, requests, per-requester patterns in; segment drive out.
// Latency and backpressure belong to the module using it; this is a pure signal grouping.
// No flow control: requesters are polled on tick, the display always accepts.
interface seg_arbiter_if;
    logic        tick;
    logic [2:0]  req;
    logic [27:0] data0;
    logic [27:0] data1;
    logic [27:0] data2;
    logic [3:0]  dpin0;
    logic [3:0]  dpin1;
    logic [3:0]  dpin2;
    logic [2:0]  blink;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic [2:0]  grant;

    modport master (
        output tick, req, data0, data1, data2, dpin0, dpin1, dpin2, blink,
        input  seg, an, dp, grant
    );

    modport slave (
        input  tick, req, data0, data1, data2, dpin0, dpin1, dpin2, blink,
        output seg, an, dp, grant
    );
endinterface

// File: rtl/seg_arbiter.sv
// Three-way priority arbiter sharing one 4-digit 7-seg display; bit 0 wins, with a minimum hold before preemption.
// Latency: outputs registered, 1 cycle after the tick edge; patterns are sampled live every cycle.
// No backpressure: requests are polled on tick only. Optional blink phase under SEG_ARBITER_BLINK_EN.
module seg_arbiter #(
    parameter int HOLD_TICKS  = 400,
    parameter int BLINK_TICKS = 100
) (
    input  logic          clock,
    input  logic          reset,
    seg_arbiter_if.slave  bus
);

    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  idx_q, idx_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic        dp_q, dp_d;
    logic [2:0]  grant_q, grant_d;

    logic        pick_vld;
    logic [1:0]  pick;
    logic        load;
    logic        advance;
    logic [27:0] data_sel;
    logic [3:0]  dpin_sel;
    logic [6:0]  digit;
    logic        blank;

`ifdef SEG_ARBITER_BLINK_EN
    localparam int BW = (2 * BLINK_TICKS > 1) ? $clog2(2 * BLINK_TICKS) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_TICKS - 1);
    localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_TICKS);
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
`endif

    always_comb begin
        pick_vld = |bus.req;
        if (bus.req[0])      pick = 2'd0;
        else if (bus.req[1]) pick = 2'd1;
        else                 pick = 2'd2;
    end

    // Owner change (load) and staying on the same owner (advance) are exclusive; neither on idle ticks.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        load    = 1'b0;
        advance = 1'b0;
        if (bus.tick) begin
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        state_d = S_GRANT;
                        owner_d = pick;
                        load    = 1'b1;
                    end
                end
                S_GRANT: begin
                    if (!bus.req[owner_q]) begin
                        load = 1'b1;
                        if (pick_vld) begin
                            owner_d = pick;
                        end else begin
                            state_d = S_IDLE;
                            owner_d = 2'd0;
                        end
                    end else if ((pick < owner_q) && (hold_q == HOLD_MAX)) begin
                        owner_d = pick;
                        load    = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    owner_d = 2'd0;
                    load    = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        hold_d = hold_q;
        idx_d  = idx_q;
        if (load) begin
            hold_d = '0;
            idx_d  = 2'd0;
        end else if (advance) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
            idx_d  = idx_q + 2'd1;
        end
    end

`ifdef SEG_ARBITER_BLINK_EN
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        if (load)
            blink_cnt_d = '0;
        else if (advance)
            blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
        blank = bus.blink[owner_d] && (blink_cnt_d >= BLINK_HALF);
    end
`else
    always_comb begin
        blank = 1'b0;
    end
`endif

    // Display follows the next-state view so it tracks the tick with one register of latency.
    always_comb begin
        case (owner_d)
            2'd0:    begin data_sel = bus.data0; dpin_sel = bus.dpin0; end
            2'd1:    begin data_sel = bus.data1; dpin_sel = bus.dpin1; end
            default: begin data_sel = bus.data2; dpin_sel = bus.dpin2; end
        endcase
        case (idx_d)
            2'd0:    digit = data_sel[6:0];
            2'd1:    digit = data_sel[13:7];
            2'd2:    digit = data_sel[20:14];
            default: digit = data_sel[27:21];
        endcase

        seg_d   = 7'h7F;
        an_d    = 4'hF;
        dp_d    = 1'b1;
        grant_d = 3'b000;
        if (state_d == S_GRANT) begin
            grant_d = 3'b001 << owner_d;
            if (!blank) begin
                seg_d = digit;
                an_d  = ~(4'b1000 >> idx_d);
                dp_d  = dpin_sel[idx_d];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= 2'd0;
            idx_q   <= 2'd0;
            hold_q  <= '0;
            seg_q   <= 7'h7F;
            an_q    <= 4'hF;
            dp_q    <= 1'b1;
            grant_q <= 3'b000;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
            grant_q <= grant_d;
        end
    end

`ifdef SEG_ARBITER_BLINK_EN
    always_ff @(posedge clock) begin
        if (reset) blink_cnt_q <= '0;
        else       blink_cnt_q <= blink_cnt_d;
    end
`endif

    assign bus.seg   = seg_q;
    assign bus.an    = an_q;
    assign bus.dp    = dp_q;
    assign bus.grant = grant_q;

endmodule

// File: tb/tb_seg_arbiter.sv
// Bench for seg_arbiter (HOLD_TICKS=4, BLINK_TICKS=2): directed scenarios then random traffic,
// every cycle compared against an owner/counter model built from the arbitration rules.
module tb_seg_arbiter;
    localparam int HT = 4;
    localparam int BT = 2;

    logic clock = 1'b0;
    logic reset;
    seg_arbiter_if bus ();

    seg_arbiter #(.HOLD_TICKS(HT), .BLINK_TICKS(BT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // model: owner -1 means idle
    int m_own, m_hold, m_idx, m_bc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int lowest(input logic [2:0] r);
        for (int k = 0; k < 3; k++) if (r[k]) return k;
        return -1;
    endfunction

    function automatic logic [27:0] pat(input int o);
        return (o == 0) ? bus.data0 : (o == 1) ? bus.data1 : bus.data2;
    endfunction

    function automatic logic [3:0] dps(input int o);
        return (o == 0) ? bus.dpin0 : (o == 1) ? bus.dpin1 : bus.dpin2;
    endfunction

    function automatic bit blank_now();
`ifdef SEG_ARBITER_BLINK_EN
        return (m_own >= 0) && bus.blink[m_own] && (m_bc >= BT);
`else
        return 1'b0;
`endif
    endfunction

    task automatic new_owner(input int o);
        m_own = o; m_hold = 0; m_idx = 0; m_bc = 0;
    endtask

    task automatic model_step();
        int lo;
        if (reset) begin
            new_owner(-1);
        end else if (bus.tick) begin
            lo = lowest(bus.req);
            if (m_own < 0) begin
                if (lo >= 0) new_owner(lo);
            end else if (!bus.req[m_own]) begin
                new_owner(lo);
            end else if (lo < m_own && m_hold == HT) begin
                new_owner(lo);
            end else begin
                m_hold = (m_hold < HT) ? m_hold + 1 : HT;
                m_idx  = (m_idx + 1) % 4;
                m_bc   = (m_bc + 1) % (2 * BT);
            end
        end
    endtask

    task automatic compare_all();
        logic [6:0] e_seg;
        logic [3:0] e_an;
        logic       e_dp;
        logic [2:0] e_gnt;
        logic [27:0] d;
        logic [3:0] p;
        e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1; e_gnt = 3'b000;
        if (m_own >= 0) begin
            e_gnt = 3'(1 << m_own);
            if (!blank_now()) begin
                d = pat(m_own);
                p = dps(m_own);
                e_seg = d[7*m_idx +: 7];
                e_an  = 4'hF & ~(4'(1 << (3 - m_idx)));
                e_dp  = p[m_idx];
            end
        end
        chk("grant", 32'(bus.grant), 32'(e_gnt));
        chk("seg",   32'(bus.seg),   32'(e_seg));
        chk("an",    32'(bus.an),    32'(e_an));
        chk("dp",    32'(bus.dp),    32'(e_dp));
    endtask

    task automatic cyc(input logic t, input logic [2:0] r);
        bus.tick = t;
        bus.req  = r;
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 3'b000);
        reset = 1'b0;
    endtask

    task automatic randomize_data();
        bus.data0 = 28'($urandom()); bus.data1 = 28'($urandom()); bus.data2 = 28'($urandom());
        bus.dpin0 = 4'($urandom());  bus.dpin1 = 4'($urandom());  bus.dpin2 = 4'($urandom());
    endtask

    initial begin
        logic [3:0] an_seq [4];
        logic [27:0] d2;
        an_seq[0] = 4'b1011; an_seq[1] = 4'b1101; an_seq[2] = 4'b1110; an_seq[3] = 4'b0111;
        reset = 1'b1;
        bus.tick = 1'b0; bus.req = 3'b000; bus.blink = 3'b000;
        randomize_data();
        new_owner(-1);
        do_reset();
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_an",    32'(bus.an),    32'hF);
        chk("rst_seg",   32'(bus.seg),   32'h7F);

        // single low-priority requester scanning its digits
        cyc(1'b1, 3'b100);
        d2 = bus.data2;
        chk("s1_grant", 32'(bus.grant), 32'b100);
        chk("s1_an",    32'(bus.an),    32'b0111);
        chk("s1_seg",   32'(bus.seg),   32'(d2[6:0]));
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 3'b100);
            chk("s1_scan", 32'(bus.an), 32'(an_seq[k]));
        end

        // higher-priority request must wait for the hold counter
        do_reset();
        cyc(1'b1, 3'b100); cyc(1'b1, 3'b100); cyc(1'b1, 3'b100);
        cyc(1'b1, 3'b101); chk("hold_keep1", 32'(bus.grant), 32'b100);
        cyc(1'b1, 3'b101); chk("hold_keep2", 32'(bus.grant), 32'b100);
        cyc(1'b1, 3'b101); chk("hold_switch", 32'(bus.grant), 32'b001);
        chk("hold_switch_an", 32'(bus.an), 32'b0111);

        // owner drop re-arbitrates without waiting, then idle
        do_reset();
        cyc(1'b1, 3'b001); chk("drop_g0", 32'(bus.grant), 32'b001);
        cyc(1'b1, 3'b010); chk("drop_g1", 32'(bus.grant), 32'b010);
        cyc(1'b1, 3'b000);
        chk("idle_grant", 32'(bus.grant), 32'h0);
        chk("idle_an",    32'(bus.an),    32'hF);
        chk("idle_seg",   32'(bus.seg),   32'h7F);

        // no tick: state frozen while req toggles
        cyc(1'b1, 3'b010);
        for (int k = 0; k < 50; k++) cyc(1'b0, 3'($urandom_range(0, 7)));
        chk("freeze_grant", 32'(bus.grant), 32'b010);

        // reset wins over a simultaneous tick
        reset = 1'b1;
        cyc(1'b1, 3'b010);
        reset = 1'b0;
        chk("rst_mid_grant", 32'(bus.grant), 32'h0);
        chk("rst_mid_an",    32'(bus.an),    32'hF);
        cyc(1'b1, 3'b110);
        chk("regrant", 32'(bus.grant), 32'b010);

        // blink phase for owner 0
        do_reset();
        bus.blink = 3'b001;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 3'b001);
`ifdef SEG_ARBITER_BLINK_EN
            chk("blink_blank", 32'(bus.an == 4'hF), 32'((k % 4) >= 2));
`else
            chk("blink_blank", 32'(bus.an == 4'hF), 32'h0);
`endif
        end

        // random traffic
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0) randomize_data();
            bus.blink = 3'($urandom_range(0, 7));
            reset = ($urandom_range(0, 59) == 0);
            cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/seg_arbiter.md
SEG_ARBITER -- requirements
Module: seg_arbiter

Interface
REQ-001 Parameter HOLD_TICKS, default 400, minimum number of ticks a grant is kept before a higher-priority requester may preempt it (2 s at a 5 ms tick).
REQ-002 Parameter BLINK_TICKS, default 100, half-period in ticks of the blink phase.
REQ-003 clock  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick  input  1  one-cycle scan strobe; all scan, hold, blink and arbitration state advances only on cycles with tick=1.
REQ-006 req  input  3  request per requester; bit 0 is highest priority, bit 2 is lowest.
REQ-007 data0, data1, data2  input  28 each  active-low segment patterns; digit d is bits [7d+6:7d], and digit 0 is leftmost.
REQ-008 dpin0, dpin1, dpin2  input  4 each  active-low decimal point per digit; bit d belongs to digit d.
REQ-009 blink  input  3  per-requester blink enable.
REQ-010 seg  output  7  active-low segments to the display.
REQ-011 an  output  4  active-low anodes; digit d drives an[3-d].
REQ-012 dp  output  1  active-low decimal point.
REQ-013 grant  output  3  one-hot current owner; 3'b000 when idle.

Function
REQ-014 The block SHALL implement two states, IDLE and GRANT(i), with the state, digit index (2 bits), hold counter and blink counter all registered.
REQ-015 In IDLE, on a tick with req!=0, the block SHALL enter GRANT(k), where k is the lowest set bit of req, and clear the hold counter and digit index.
REQ-016 In GRANT(i), on a tick with req[i]=0, the block SHALL re-arbitrate immediately, regardless of the hold counter, to GRANT(lowest set bit of req) or to IDLE if req=0.
REQ-017 In GRANT(i), on a tick with req[i]=1 and some req[j]=1 with j<i, the block SHALL switch to GRANT(lowest such j) only if the hold counter equals HOLD_TICKS; otherwise it SHALL keep GRANT(i).
REQ-018 Lower-priority requests SHALL never preempt the current owner.
REQ-019 While in GRANT, the hold counter SHALL increment on each tick and saturate at HOLD_TICKS; it SHALL clear on every change of owner.
REQ-020 The digit index SHALL advance on each tick and wrap 3->0; on a tick where the owner changes, it SHALL load 0 instead of advancing.
REQ-021 In GRANT(i), on the cycle after any update: an SHALL have only bit [3-idx] low, seg SHALL equal data_i digit idx, and dp SHALL equal dpin_i[idx]; the data is sampled live, not latched.
REQ-022 In IDLE: seg=7'h7F, an=4'hF, dp=1, grant=0.
REQ-023 grant SHALL change on the same clock edge as the state, and all outputs SHALL be registered with a latency of 1 cycle from the tick.
REQ-024 Cycles with tick=0 SHALL hold all state; req changes between ticks SHALL be ignored until the next tick.

Reset
REQ-025 While reset=1 on a clock edge, the block SHALL go to IDLE with digit index=0, hold counter=0, blink counter=0, seg=7'h7F, an=4'hF, dp=1 and grant=0.
REQ-026 Reset SHALL take priority over tick; reset asserted mid-grant SHALL blank the outputs on the next edge, and re-arbitration SHALL occur on the first tick after reset is released.

Configuration
REQ-027 With SEG_ARBITER_BLINK_EN defined, a blink counter SHALL count ticks 0..2*BLINK_TICKS-1 and wrap, restarting at 0 on every owner change.
REQ-028 Under SEG_ARBITER_BLINK_EN, while blink[owner]=1 and the counter is >= BLINK_TICKS, the outputs SHALL be seg=7'h7F, an=4'hF, dp=1; grant and scan are unaffected.
REQ-029 Without SEG_ARBITER_BLINK_EN, the blink input and blink counter SHALL be absent from logic, and the display SHALL never blank while granted.

Verification (HOLD_TICKS=4, BLINK_TICKS=2)
REQ-030 Bench SHALL cover: req=3'b100 on tick 1 -> grant=3'b100, an=4'b0111, seg=data2[6:0]; over ticks 2..5, an=1011,1101,1110,0111.
REQ-031 Bench SHALL cover: owner 2 held, req=3'b101 asserted after 2 ticks -> grant stays 3'b100 until the hold counter reaches 4, then switches to 3'b001 with an=4'b0111.
REQ-032 Bench SHALL cover: owner 0, req drops to 3'b010 after 1 tick -> next tick grant=3'b010 (no hold wait); req=0 -> IDLE with an=4'hF, seg=7'h7F.
REQ-033 Bench SHALL cover: tick=0 for 50 cycles while req toggles -> outputs and grant constant.
REQ-034 Bench SHALL cover: reset pulsed mid-grant with tick=1 on the same cycle -> outputs blank and grant=0 next edge; regrant on the first post-reset tick.
REQ-035 Bench SHALL cover, with the macro defined and blink=3'b001 with owner 0: display on for 2 ticks, blank for 2, repeating; without the macro it is never blank.
